// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one UART TX PHY between NUM_REQ word sources.
// Optional build macro UART_ARB_PRIORITY_EN makes requester 0 strict-priority in IDLE.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 9,
    parameter int MAX_BURST    = 8,
    parameter int IDLE_TIMEOUT = 16,
    localparam int IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic                      phy_vld,
    output logic [DATA_W-1:0]         phy_data,
    input  logic                      phy_rdy,
    output logic [IW-1:0]             grant_id,
    output logic                      busy
);

    localparam logic [7:0] MAX_B  = 8'(MAX_BURST);
    localparam logic [7:0] IDLE_T = 8'(IDLE_TIMEOUT);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [7:0]      burst_q, burst_d;
    logic [7:0]      idle_q, idle_d;
    logic            prio_q, prio_d;

    logic            can_load;
    logic            owner_vld;
    logic            owner_last;
    logic [DATA_W-1:0] owner_data;
    logic            accept;
    logic            rel;
    logic            found;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   next_rr;

    assign grant_id = owner_q;
    assign busy     = (state_q == LOCKED) || phy_vld;

    // Round-robin search from the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = IW'((32'(rr_q) + k) % NUM_REQ);
            if (!found && req_vld[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        can_load   = !phy_vld || phy_rdy;
        owner_vld  = req_vld[owner_q];
        owner_last = req_last[owner_q];
        owner_data = req_data[owner_q*DATA_W +: DATA_W];
        accept     = (state_q == LOCKED) && owner_vld && can_load;
        next_rr    = (owner_q == IW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;

        req_rdy = '0;
        if (state_q == LOCKED && can_load) begin
            req_rdy[owner_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        idle_d  = idle_q;
        prio_d  = prio_q;
        rel     = 1'b0;

        case (state_q)
            IDLE: begin
`ifdef UART_ARB_PRIORITY_EN
                if (req_vld[0]) begin
                    state_d = LOCKED;
                    owner_d = '0;
                    burst_d = '0;
                    idle_d  = '0;
                    prio_d  = 1'b1;
                end else
`endif
                if (found) begin
                    state_d = LOCKED;
                    owner_d = winner;
                    burst_d = '0;
                    idle_d  = '0;
                    prio_d  = 1'b0;
                end
            end

            LOCKED: begin
                if (accept) begin
                    burst_d = burst_q + 8'd1;
                    if (owner_last || burst_d == MAX_B) begin
                        rel = 1'b1;
                    end
                end
                // Backpressure with the owner still valid counts as activity, not idleness.
                if (owner_vld) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 8'd1;
                    if (idle_d == IDLE_T) begin
                        rel = 1'b1;
                    end
                end
                if (rel) begin
                    state_d = IDLE;
                    if (!prio_q) begin
                        rr_d = next_rr;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            burst_q <= '0;
            idle_q  <= '0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
            prio_q  <= prio_d;
        end
    end

    // One-entry output register; a new word may replace the old one in the cycle it is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            phy_vld  <= 1'b0;
            phy_data <= '0;
        end else if (accept) begin
            phy_vld  <= 1'b1;
            phy_data <= owner_data;
        end else if (phy_rdy) begin
            phy_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle table for the basic grant path, scoreboarded packet sequences.
// Build with UART_ARB_PRIORITY_EN defined to check the strict-priority variant.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_vld;
    logic [35:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_rdy;
    logic        phy_vld;
    logic [8:0]  phy_data;
    logic        phy_rdy;
    logic [1:0]  grant_id;
    logic        busy;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_W(9),
        .MAX_BURST(8),
        .IDLE_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_vld(req_vld),
        .req_data(req_data),
        .req_last(req_last),
        .req_rdy(req_rdy),
        .phy_vld(phy_vld),
        .phy_data(phy_data),
        .phy_rdy(phy_rdy),
        .grant_id(grant_id),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] data;
        logic       last;
        int         gap;
    } word_t;

    typedef struct {
        logic [3:0]  vld;
        logic [35:0] data;
        logic [3:0]  last;
        logic        prdy;
        logic [3:0]  e_rdy;
        logic        e_pvld;
        logic [8:0]  e_pdata;
        logic [1:0]  e_gid;
        logic        e_busy;
    } vec_t;

    word_t      rq[4][$];
    logic [8:0] sb[$];
    logic [3:0] acc;
    logic       prdy_ctl;
    int         checks;
    int         errors;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] wd(input int id, input int seq);
        return {3'(id), 6'(seq)};
    endfunction

    task automatic push_pkt(input int id, input int n, input int gap_at, input int gap_len);
        word_t w;
        for (int s = 0; s < n; s++) begin
            w.data = wd(id, s);
            w.last = (s == n - 1);
            w.gap  = (s == gap_at) ? gap_len : 0;
            rq[id].push_back(w);
        end
    endtask

    task automatic exp_words(input int id, input int from, input int to);
        for (int s = from; s <= to; s++) sb.push_back(wd(id, s));
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) rq[i].delete();
        sb.delete();
        acc      = '0;
        req_vld  = '0;
        req_last = '0;
        req_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_all();
        prdy_ctl = 1'b1;
        phy_rdy  = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_phy_vld", phy_vld, 0);
        chk("rst_phy_data", phy_data, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
    endtask

    // One cycle: retire last cycle's handshakes, drive heads of the requester queues, observe the PHY side.
    task automatic step();
        logic [8:0] e;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (acc[i] && rq[i].size() > 0) rq[i].delete(0);
        end
        for (int i = 0; i < 4; i++) begin
            if (rq[i].size() > 0 && rq[i][0].gap > 0) begin
                req_vld[i]  = 1'b0;
                req_last[i] = 1'b0;
                rq[i][0].gap = rq[i][0].gap - 1;
            end else if (rq[i].size() > 0) begin
                req_vld[i]           = 1'b1;
                req_data[i*9 +: 9]   = rq[i][0].data;
                req_last[i]          = rq[i][0].last;
            end else begin
                req_vld[i]  = 1'b0;
                req_last[i] = 1'b0;
            end
        end
        phy_rdy = prdy_ctl;
        #1;
        acc = req_vld & req_rdy;
        chk("req_rdy_onehot", $onehot0(req_rdy), 1);
        if (phy_vld && phy_rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL phy_unexpected actual=%0h expected=none t=%0t", phy_data, $time);
            end else begin
                e = sb.pop_front();
                chk("phy_word", phy_data, e);
            end
        end
    endtask

    function automatic int pending();
        int n = sb.size();
        for (int i = 0; i < 4; i++) n += rq[i].size();
        return n;
    endfunction

    task automatic run_done(input string nm, input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(nm, pending(), 0);
    endtask

    vec_t tbl[9];
    logic [35:0] lanes;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        prdy_ctl = 1'b1;
        phy_rdy  = 1'b1;
        clear_all();

        lanes = {9'h0AA, 9'h000, 9'h000, 9'h155};
        //          vld      data   last     prdy  e_rdy    pvld  pdata   gid   busy
        tbl[0] = '{4'b0001, lanes, 4'b1111, 1'b1, 4'b0000, 1'b0, 9'h000, 2'd0, 1'b0};
        tbl[1] = '{4'b0001, lanes, 4'b1111, 1'b1, 4'b0001, 1'b0, 9'h000, 2'd0, 1'b1};
        tbl[2] = '{4'b0000, lanes, 4'b1111, 1'b1, 4'b0000, 1'b1, 9'h155, 2'd0, 1'b1};
        tbl[3] = '{4'b0000, lanes, 4'b1111, 1'b1, 4'b0000, 1'b0, 9'h000, 2'd0, 1'b0};
        tbl[4] = '{4'b1001, lanes, 4'b1111, 1'b1, 4'b0000, 1'b0, 9'h000, 2'd0, 1'b0};
`ifdef UART_ARB_PRIORITY_EN
        tbl[5] = '{4'b1001, lanes, 4'b1111, 1'b1, 4'b0001, 1'b0, 9'h000, 2'd0, 1'b1};
        tbl[6] = '{4'b1000, lanes, 4'b1111, 1'b1, 4'b0000, 1'b1, 9'h155, 2'd0, 1'b1};
        tbl[7] = '{4'b1000, lanes, 4'b1111, 1'b1, 4'b1000, 1'b0, 9'h000, 2'd3, 1'b1};
        tbl[8] = '{4'b0000, lanes, 4'b1111, 1'b1, 4'b0000, 1'b1, 9'h0AA, 2'd3, 1'b1};
`else
        tbl[5] = '{4'b1001, lanes, 4'b1111, 1'b1, 4'b1000, 1'b0, 9'h000, 2'd3, 1'b1};
        tbl[6] = '{4'b0001, lanes, 4'b1111, 1'b1, 4'b0000, 1'b1, 9'h0AA, 2'd3, 1'b1};
        tbl[7] = '{4'b0001, lanes, 4'b1111, 1'b1, 4'b0001, 1'b0, 9'h000, 2'd0, 1'b1};
        tbl[8] = '{4'b0000, lanes, 4'b1111, 1'b1, 4'b0000, 1'b1, 9'h155, 2'd0, 1'b1};
`endif

        do_reset();
        for (int r = 0; r < 9; r++) begin
            @(negedge clk);
            req_vld  = tbl[r].vld;
            req_data = tbl[r].data;
            req_last = tbl[r].last;
            phy_rdy  = tbl[r].prdy;
            #1;
            chk($sformatf("tbl%0d_req_rdy", r), req_rdy, tbl[r].e_rdy);
            chk($sformatf("tbl%0d_phy_vld", r), phy_vld, tbl[r].e_pvld);
            if (tbl[r].e_pvld) chk($sformatf("tbl%0d_phy_data", r), phy_data, tbl[r].e_pdata);
            chk($sformatf("tbl%0d_grant_id", r), grant_id, tbl[r].e_gid);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
        end

        // All four sources with 2-word packets: strict rotation, packets never interleave.
        do_reset();
        for (int i = 0; i < 4; i++) push_pkt(i, 2, -1, 0);
        for (int i = 0; i < 4; i++) exp_words(i, 0, 1);
        run_done("rr_four_done", 200);

        // 12-word packet hits the burst limit; the waiting source slips in before the tail.
        do_reset();
        push_pkt(2, 12, -1, 0);
        push_pkt(3, 2, -1, 0);
        exp_words(2, 0, 7);
        exp_words(3, 0, 1);
        exp_words(2, 8, 11);
        run_done("burst_split_done", 300);

        // Owner stalls 16 cycles: timeout releases to source 2 before the packet resumes.
        do_reset();
        push_pkt(1, 4, 2, 16);
        push_pkt(2, 2, -1, 0);
        exp_words(1, 0, 1);
        exp_words(2, 0, 1);
        exp_words(1, 2, 3);
        run_done("timeout16_done", 300);

        // One cycle short of the timeout: the owner keeps the grant.
        do_reset();
        push_pkt(1, 4, 2, 15);
        push_pkt(2, 2, -1, 0);
        exp_words(1, 0, 3);
        exp_words(2, 0, 1);
        run_done("timeout15_done", 300);

        // PHY backpressure for 20 cycles with the buffer full: no timeout, no loss or duplication.
        do_reset();
        push_pkt(0, 6, -1, 0);
        push_pkt(1, 2, -1, 0);
        exp_words(0, 0, 5);
        exp_words(1, 0, 1);
        for (int c = 0; c < 3; c++) step();
        prdy_ctl = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("stall_phy_vld", phy_vld, 1);
            chk("stall_phy_data", phy_data, wd(0, 1));
            chk("stall_req_rdy", req_rdy, 0);
            chk("stall_grant_id", grant_id, 0);
        end
        prdy_ctl = 1'b1;
        run_done("stall_resume_done", 200);

        // Reset mid-burst: everything back to reset values in the next cycle.
        do_reset();
        push_pkt(2, 12, -1, 0);
        exp_words(2, 0, 11);
        for (int c = 0; c < 6; c++) step();
        chk("pre_rst_grant_id", grant_id, 2);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_phy_vld", phy_vld, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_phy_vld", phy_vld, 0);
        chk("midrst_req_rdy", req_rdy, 0);
        chk("midrst_grant_id", grant_id, 0);
        chk("midrst_busy", busy, 0);
        reset = 1'b0;
        clear_all();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
